// File: rtl/usb_phy_pkg.sv
// -----------------------------------------------------------------------------
// usb_phy_pkg
//   Shared types for the USB PHY receive path.
//   - line_state_t : decoded state of the dp/dn pair for one bit sample
//   - rx_state_t   : receive FSM state (hunting SYNC, in packet, in EOP)
//   - decode_line  : maps raw (dp, dn) plus polarity mode to a line state
// -----------------------------------------------------------------------------
package usb_phy_pkg;

   typedef enum logic [1:0] {
      LS_SE0   = 2'd0,
      LS_DATA0 = 2'd1,
      LS_DATA1 = 2'd2,
      LS_SE1   = 2'd3
   } line_state_t;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_ACTIVE = 2'd1,
      RX_EOP    = 2'd2
   } rx_state_t;

   // HS and FS use opposite differential polarity for DATA1/DATA0;
   // single-ended states are polarity independent.
   function automatic line_state_t decode_line(input logic dp, input logic dn,
                                               input logic hs);
      line_state_t ls;
      case ({dp, dn})
         2'b00:   ls = LS_SE0;
         2'b11:   ls = LS_SE1;
         2'b10:   ls = hs ? LS_DATA1 : LS_DATA0;
         default: ls = hs ? LS_DATA0 : LS_DATA1;
      endcase
      return ls;
   endfunction

endpackage

// File: rtl/usb_sync2.sv
// -----------------------------------------------------------------------------
// usb_sync2
//   Two-flop synchronizer for one asynchronous pad input.
//   Ports:
//     i_clk   : destination clock
//     i_rst_n : async active-low reset, clears both stages
//     i_d     : asynchronous input
//     o_q     : synchronized output (stage 2)
// -----------------------------------------------------------------------------
module usb_sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic stage1;

   // NOTE: non-blocking assignments make the two stages shift one per clock;
   // blocking ones would collapse them into a single flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stage1 <= 1'b0;
         o_q    <= 1'b0;
      end else begin
         stage1 <= i_d;
         o_q    <= stage1;
      end
   end

endmodule

// File: rtl/line_receiver.sv
// -----------------------------------------------------------------------------
// line_receiver
//   Receive-side line decoder between the pads and the NRZI decode path.
//   Synchronizes dp/dn, decodes one line state per bit strobe, hunts for SYNC,
//   forwards packet bits, recognises EOP and aborts on line errors.
//   Ports:
//     i_clk, i_rst_n   : clock, async active-low reset
//     i_dp, i_dn       : raw pad inputs (asynchronous)
//     i_bit_en         : one-cycle strobe per bit time
//     i_hs_mode        : 1 = HS polarity, 0 = FS polarity (sampled with the bit)
//     i_rx_enable      : 0 forces IDLE silently (tie to ~oe of our driver)
//     o_nrzi_data/o_nrzi_valid : forwarded NRZI bit and its qualifier
//     o_packet_start   : pulse when SYNC matched
//     o_packet_end     : pulse when a valid EOP completed
//     o_rx_active      : high from packet start until end/abort
//     o_rx_error       : pulse on line error (packet aborted)
//     o_line_state     : decoded line state of the last bit sample
// -----------------------------------------------------------------------------
module line_receiver
   import usb_phy_pkg::*;
#(
   parameter int                  SYNC_LEN     = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_NRZI    = 8'b01010100,
   parameter int                  EOP_SE0_BITS = 2,
   parameter int                  MAX_BITS     = 8192,
   parameter int                  CNT_W        = $clog2(MAX_BITS+1)
)(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_dp,
   input  logic       i_dn,
   input  logic       i_bit_en,
   input  logic       i_hs_mode,
   input  logic       i_rx_enable,
   output logic       o_nrzi_data,
   output logic       o_nrzi_valid,
   output logic       o_packet_start,
   output logic       o_packet_end,
   output logic       o_rx_active,
   output logic       o_rx_error,
   output logic [1:0] o_line_state
);

   localparam int SE0_W = $clog2(EOP_SE0_BITS+1);

   logic                dp_s, dn_s;
   line_state_t         ls;
   logic                ls_data;
   logic                ls_bit;
   logic [SYNC_LEN-1:0] sr_next;

   rx_state_t           state;
   logic [SYNC_LEN-1:0] sync_sr;
   logic [CNT_W-1:0]    bit_cnt;
   logic [SE0_W-1:0]    se0_cnt;

   usb_sync2 u_sync_dp (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_dp), .o_q(dp_s));
   usb_sync2 u_sync_dn (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_dn), .o_q(dn_s));

   assign ls      = decode_line(dp_s, dn_s, i_hs_mode);
   assign ls_data = (ls == LS_DATA0) || (ls == LS_DATA1);
   assign ls_bit  = (ls == LS_DATA1);
   // Newest bit enters at the LSB so the oldest SYNC bit ends up at the MSB.
   assign sr_next = {sync_sr[SYNC_LEN-2:0], ls_bit};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= RX_IDLE;
         sync_sr        <= '0;
         bit_cnt        <= '0;
         se0_cnt        <= '0;
         o_nrzi_data    <= 1'b0;
         o_nrzi_valid   <= 1'b0;
         o_packet_start <= 1'b0;
         o_packet_end   <= 1'b0;
         o_rx_active    <= 1'b0;
         o_rx_error     <= 1'b0;
         o_line_state   <= LS_SE0;
      end else begin
         // Pulses default low so each one lasts exactly one cycle.
         o_nrzi_valid   <= 1'b0;
         o_packet_start <= 1'b0;
         o_packet_end   <= 1'b0;
         o_rx_error     <= 1'b0;

         if (i_bit_en) o_line_state <= ls;

         if (!i_rx_enable) begin
            // Our own driver owns the line: abort silently, no end/error pulse.
            state       <= RX_IDLE;
            sync_sr     <= '0;
            o_rx_active <= 1'b0;
         end else if (i_bit_en) begin
            case (state)
               RX_IDLE: begin
                  if (ls_data) begin
                     sync_sr <= sr_next;
                     if (sr_next == SYNC_NRZI) begin
                        o_packet_start <= 1'b1;
                        o_rx_active    <= 1'b1;
                        bit_cnt        <= '0;
                        state          <= RX_ACTIVE;
                     end
                  end else begin
                     sync_sr <= '0;
                  end
               end
               RX_ACTIVE: begin
                  if (ls_data) begin
                     if (bit_cnt == CNT_W'(MAX_BITS)) begin
                        // Overlong packet: drop this bit and abort.
                        o_rx_error  <= 1'b1;
                        o_rx_active <= 1'b0;
                        sync_sr     <= '0;
                        state       <= RX_IDLE;
                     end else begin
                        o_nrzi_data  <= ls_bit;
                        o_nrzi_valid <= 1'b1;
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                     end
                  end else if (ls == LS_SE0) begin
                     se0_cnt <= SE0_W'(1);
                     state   <= RX_EOP;
                  end else begin
                     o_rx_error  <= 1'b1;
                     o_rx_active <= 1'b0;
                     sync_sr     <= '0;
                     state       <= RX_IDLE;
                  end
               end
               RX_EOP: begin
                  if (ls == LS_SE0) begin
                     if (se0_cnt != SE0_W'(EOP_SE0_BITS)) se0_cnt <= se0_cnt + SE0_W'(1);
                  end else begin
                     // Any non-SE0 ends the packet; only a long-enough SE0 run
                     // followed by a data state is a valid EOP.
                     if (ls_data && (se0_cnt >= SE0_W'(EOP_SE0_BITS)))
                        o_packet_end <= 1'b1;
                     else
                        o_rx_error   <= 1'b1;
                     o_rx_active <= 1'b0;
                     sync_sr     <= '0;
                     state       <= RX_IDLE;
                  end
               end
               default: begin
                  o_rx_active <= 1'b0;
                  sync_sr     <= '0;
                  state       <= RX_IDLE;
               end
            endcase
         end
      end
   end

endmodule
